// File: rtl/axil_read_narrowing_adapter.sv
// AXI-Lite read-channel width adapter: a narrow requester reads a wide memory by selecting
// one NARROW_W lane of each wide response, with a small FIFO of lane indices per outstanding read.
module axil_read_narrowing_adapter #(
    parameter  int WIDE_W          = 64,
    parameter  int NARROW_W        = 32,
    parameter  int ADDR_W          = 64,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [NARROW_W-1:0] s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rvalid,
    input  logic                s_rready,

    output logic [ADDR_W-1:0]   m_araddr,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [WIDE_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready,

    input  logic                flush,
    output logic [CNT_W-1:0]    outstanding,
    output logic                err_unexpected_rsp
);

    localparam int RATIO   = WIDE_W / NARROW_W;
    localparam int LANE_W  = $clog2(RATIO);
    localparam int LANE_LO = $clog2(NARROW_W / 8);
    localparam int PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    generate
        if ((RATIO < 2) || (RATIO * NARROW_W != WIDE_W) || ((RATIO & (RATIO - 1)) != 0)
            || (MAX_OUTSTANDING < 1)) begin : g_bad_params
            $error("axil_read_narrowing_adapter: unsupported WIDE_W/NARROW_W/MAX_OUTSTANDING");
        end
    endgenerate

    logic [PTR_W-1:0]           wr_ptr_reg;
    logic [PTR_W-1:0]           wr_ptr_next;
    logic [PTR_W-1:0]           rd_ptr_reg;
    logic [PTR_W-1:0]           rd_ptr_next;
    logic [CNT_W-1:0]           count_reg;
    logic [CNT_W-1:0]           count_next;
    logic                       err_reg;
    logic [MAX_OUTSTANDING-1:0] discard_reg;
    logic [MAX_OUTSTANDING-1:0] discard_next;
    logic [LANE_W-1:0]          lane_mem [MAX_OUTSTANDING];

    logic                       can_accept;
    logic                       push;
    logic                       pop;
    logic                       not_empty;
    logic                       head_discard;
    logic                       head_forward;
    logic                       head_drop;
    logic [LANE_W-1:0]          head_lane;
    logic [LANE_W-1:0]          s_lane;
    logic [NARROW_W-1:0]        lane_data [RATIO];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Address channel: pure pass-through with lane bits cleared.
    generate
        for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_addr
            if ((gi >= LANE_LO) && (gi < LANE_LO + LANE_W)) begin : g_lane_bit
                assign m_araddr[gi] = 1'b0;
            end else begin : g_pass_bit
                assign m_araddr[gi] = s_araddr[gi];
            end
        end
    endgenerate

    assign s_lane     = s_araddr[LANE_LO +: LANE_W];
    assign can_accept = !rst && !flush && (count_reg < CNT_W'(MAX_OUTSTANDING));
    assign m_arvalid  = s_arvalid && can_accept;
    assign s_arready  = m_arready && can_accept;
    assign push       = s_arvalid && s_arready;

    assign not_empty    = (count_reg != '0);
    assign head_lane    = lane_mem[rd_ptr_reg];
    assign head_discard = discard_reg[rd_ptr_reg];
    assign head_forward = !rst && not_empty && !head_discard && !flush;
    assign head_drop    = !rst && not_empty && (head_discard || flush);

    assign s_rvalid = head_forward && m_rvalid;
    assign m_rready = head_forward ? s_rready : head_drop;
    assign pop      = m_rvalid && m_rready;

    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
            assign lane_data[gi] = m_rdata[gi*NARROW_W +: NARROW_W];
        end
    endgenerate

    assign s_rdata = lane_data[head_lane];
    assign s_rresp = m_rresp;

    assign outstanding        = count_reg;
    assign err_unexpected_rsp = err_reg;

    // A flush marks every slot; slots that are not live get overwritten with discard=0 on push.
    generate
        for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_discard
            assign discard_next[gi] = flush ? 1'b1 :
                                      (push && (wr_ptr_reg == PTR_W'(gi))) ? 1'b0 :
                                      discard_reg[gi];
        end
    endgenerate

    always_comb begin
        wr_ptr_next = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        rd_ptr_next = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        count_next  = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            discard_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            discard_reg <= discard_next;
            if (!not_empty && m_rvalid) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Lane storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            lane_mem[wr_ptr_reg] <= s_lane;
        end
    end

endmodule

// File: tb/tb_axil_read_narrowing_adapter.sv
// Directed bench for axil_read_narrowing_adapter: default 64/32 instance plus a 128/32 instance.
module tb_axil_read_narrowing_adapter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // default-parameter instance
    logic [63:0] s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic [63:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [63:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0;
    logic        m_rvalid = 1'b0;
    logic        m_rready;
    logic        flush = 1'b0;
    logic [2:0]  outstanding;
    logic        err_unexpected_rsp;

    // 128-bit instance
    logic [63:0]  w_s_araddr = '0;
    logic         w_s_arvalid = 1'b0;
    logic         w_s_arready;
    logic [31:0]  w_s_rdata;
    logic [1:0]   w_s_rresp;
    logic         w_s_rvalid;
    logic         w_s_rready = 1'b0;
    logic [63:0]  w_m_araddr;
    logic         w_m_arvalid;
    logic         w_m_arready = 1'b0;
    logic [127:0] w_m_rdata = '0;
    logic [1:0]   w_m_rresp = '0;
    logic         w_m_rvalid = 1'b0;
    logic         w_m_rready;
    logic         w_flush = 1'b0;
    logic [2:0]   w_outstanding;
    logic         w_err;

    int total = 0;
    int bad   = 0;

    axil_read_narrowing_adapter u_dut (
        .clk(clk), .rst(rst),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .flush(flush), .outstanding(outstanding), .err_unexpected_rsp(err_unexpected_rsp)
    );

    axil_read_narrowing_adapter #(.WIDE_W(128), .NARROW_W(32), .ADDR_W(64), .MAX_OUTSTANDING(4)) u_wide (
        .clk(clk), .rst(rst),
        .s_araddr(w_s_araddr), .s_arvalid(w_s_arvalid), .s_arready(w_s_arready),
        .s_rdata(w_s_rdata), .s_rresp(w_s_rresp), .s_rvalid(w_s_rvalid), .s_rready(w_s_rready),
        .m_araddr(w_m_araddr), .m_arvalid(w_m_arvalid), .m_arready(w_m_arready),
        .m_rdata(w_m_rdata), .m_rresp(w_m_rresp), .m_rvalid(w_m_rvalid), .m_rready(w_m_rready),
        .flush(w_flush), .outstanding(w_outstanding), .err_unexpected_rsp(w_err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] rsp_data [3];
    logic [31:0] rsp_exp  [3];

    initial begin
        // reset state with requests pending on the inputs
        s_arvalid = 1'b1;
        m_arready = 1'b1;
        s_rready  = 1'b1;
        m_rvalid  = 1'b0;
        tick();
        tick();
        check("rst_arready", s_arready, 0);
        check("rst_marvalid", m_arvalid, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_err", err_unexpected_rsp, 0);
        check("rst_mrready", m_rready, 0);
        check("rst_srvalid", s_rvalid, 0);
        s_arvalid = 1'b0;
        rst = 1'b0;
        tick();

        // basic read
        s_araddr  = 64'h1004;
        s_arvalid = 1'b1;
        #1;
        check("basic_araddr", m_araddr, 64'h1000);
        check("basic_arready", s_arready, 1);
        tick();
        s_arvalid = 1'b0;
        check("basic_out1", outstanding, 1);
        m_rvalid = 1'b1;
        m_rdata  = 64'hAAAA_BBBB_CCCC_DDDD;
        m_rresp  = 2'b10;
        #1;
        check("basic_rvalid", s_rvalid, 1);
        check("basic_rdata", s_rdata, 32'hAAAA_BBBB);
        check("basic_rresp", s_rresp, 2'b10);
        tick();
        m_rvalid = 1'b0;
        m_rresp  = 2'b00;
        check("basic_out0", outstanding, 0);

        // four pipelined reads, responses delayed
        s_arvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_araddr = 64'(i * 4);
            tick();
        end
        s_araddr = 64'h40;
        check("pipe_out4", outstanding, 4);
        check("pipe_arready_full", s_arready, 0);
        check("pipe_marvalid_full", m_arvalid, 0);
        // full boundary: pop and a pending request in the same cycle
        m_rvalid = 1'b1;
        m_rdata  = 64'h1111_1111_2222_2222;
        #1;
        check("full_arready", s_arready, 0);
        check("pipe_rdata0", s_rdata, 32'h2222_2222);
        tick();
        s_arvalid = 1'b0;
        check("full_out3", outstanding, 3);
        rsp_data[0] = 64'h3333_3333_4444_4444; rsp_exp[0] = 32'h3333_3333;
        rsp_data[1] = 64'h5555_5555_6666_6666; rsp_exp[1] = 32'h6666_6666;
        rsp_data[2] = 64'h7777_7777_8888_8888; rsp_exp[2] = 32'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            m_rdata = rsp_data[i];
            #1;
            check($sformatf("pipe_rdata%0d", i + 1), s_rdata, rsp_exp[i]);
            tick();
        end
        m_rvalid = 1'b0;
        check("pipe_out0", outstanding, 0);

        // backpressure on a forwarded head
        s_araddr  = 64'h4;
        s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        m_rvalid  = 1'b1;
        m_rdata   = 64'h9999_0000_1234_5678;
        #1;
        check("bp_mrready", m_rready, 0);
        check("bp_srvalid", s_rvalid, 1);
        tick();
        check("bp_out_held", outstanding, 1);
        check("bp_rdata_held", s_rdata, 32'h9999_0000);
        s_rready = 1'b1;
        #1;
        check("bp_mrready_rel", m_rready, 1);
        tick();
        m_rvalid = 1'b0;
        check("bp_out0", outstanding, 0);

        // flush with three reads outstanding, then a read issued right after
        s_arvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_araddr = 64'h10 + 64'(i * 4);
            tick();
        end
        check("fl_out3", outstanding, 3);
        s_araddr = 64'h24;
        flush    = 1'b1;
        #1;
        check("fl_arready", s_arready, 0);
        check("fl_mrready", m_rready, 1);
        check("fl_srvalid", s_rvalid, 0);
        tick();
        flush = 1'b0;
        #1;
        check("fl_post_arready", s_arready, 1);
        check("fl_post_araddr", m_araddr, 64'h20);
        tick();
        s_arvalid = 1'b0;
        check("fl_out4", outstanding, 4);
        m_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_rdata = 64'hBAD0_0000_BAD0_0000 + 64'(i);
            #1;
            check($sformatf("fl_drop%0d_srvalid", i), s_rvalid, 0);
            check($sformatf("fl_drop%0d_mrready", i), m_rready, 1);
            tick();
        end
        m_rdata = 64'h1111_2222_3333_4444;
        #1;
        check("fl_fwd_srvalid", s_rvalid, 1);
        check("fl_fwd_rdata", s_rdata, 32'h1111_2222);
        tick();
        m_rvalid = 1'b0;
        check("fl_out0", outstanding, 0);

        // unexpected response
        m_rvalid = 1'b1;
        #1;
        check("err_mrready", m_rready, 0);
        check("err_srvalid", s_rvalid, 0);
        tick();
        m_rvalid = 1'b0;
        check("err_set", err_unexpected_rsp, 1);
        tick();
        check("err_sticky", err_unexpected_rsp, 1);

        // reset mid-operation
        s_arvalid = 1'b1;
        s_araddr  = 64'h30;
        tick();
        s_araddr  = 64'h34;
        tick();
        s_arvalid = 1'b0;
        check("mrst_out2", outstanding, 2);
        rst = 1'b1;
        #1;
        check("mrst_out0", outstanding, 0);
        check("mrst_err", err_unexpected_rsp, 0);
        check("mrst_arready", s_arready, 0);
        tick();
        rst = 1'b0;
        tick();
        s_araddr  = 64'h3C;
        s_arvalid = 1'b1;
        #1;
        check("mrst_idle_arready", s_arready, 1);
        tick();
        s_arvalid = 1'b0;
        check("mrst_out1", outstanding, 1);
        m_rvalid = 1'b1;
        m_rdata  = 64'hCAFE_F00D_0BAD_BEEF;
        #1;
        check("mrst_rdata", s_rdata, 32'hCAFE_F00D);
        tick();
        m_rvalid = 1'b0;
        check("mrst_out_end", outstanding, 0);
        check("mrst_err_end", err_unexpected_rsp, 0);

        // 128-bit wide instance
        w_s_rready  = 1'b1;
        w_m_arready = 1'b1;
        w_s_araddr  = 64'h200C;
        w_s_arvalid = 1'b1;
        #1;
        check("wide_araddr", w_m_araddr, 64'h2000);
        tick();
        w_s_araddr = 64'h2008;
        tick();
        w_s_arvalid = 1'b0;
        check("wide_out2", w_outstanding, 2);
        w_m_rvalid = 1'b1;
        w_m_rdata  = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
        #1;
        check("wide_rdata_c", w_s_rdata, 32'hDDDD_DDDD);
        tick();
        #1;
        check("wide_rdata_8", w_s_rdata, 32'hCCCC_CCCC);
        tick();
        w_m_rvalid = 1'b0;
        check("wide_out0", w_outstanding, 0);
        check("wide_err", w_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axil_read_narrowing_adapter.md
AXIL_READ_NARROWING_ADAPTER -- requirements
Module: axil_read_narrowing_adapter

Interface
REQ-001 SHALL have parameter WIDE_W, default 64, the data width of the downstream (memory-side) read channel.
REQ-002 SHALL have parameter NARROW_W, default 32, the data width of the upstream (requester-side) read channel.
REQ-003 SHALL have parameter ADDR_W, default 64, the address width on both sides.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, the maximum number of accepted reads still awaiting a response.
REQ-005 SHALL have a single clock; reset is asynchronous and active-high:
- clk  in  1  sole clock
- rst  in  1  async active-high reset
REQ-006 SHALL provide the upstream narrow read slave ports:
- s_araddr  in  ADDR_W  read address
- s_arvalid  in  1  address valid
- s_arready  out  1  address accepted
- s_rdata  out  NARROW_W  selected lane
- s_rresp  out  2  passed-through response
- s_rvalid  out  1  data valid
- s_rready  in  1  data accepted
REQ-007 SHALL provide the downstream wide read master ports:
- m_araddr  out  ADDR_W  lane-aligned address
- m_arvalid  out  1
- m_arready  in  1
- m_rdata  in  WIDE_W
- m_rresp  in  2
- m_rvalid  in  1
- m_rready  out  1
REQ-008 SHALL provide the control and status ports:
- flush  in  1  discard all outstanding responses (branch invalidate)
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  accepted-but-unanswered reads
- err_unexpected_rsp  out  1  sticky: m_rvalid seen with no outstanding read

Function
REQ-009 SHALL support only WIDE_W = R*NARROW_W, with R a power of two and R>=2, and MAX_OUTSTANDING>=1.
REQ-010 SHALL derive the lane index from s_araddr bits [log2(WIDE_W/8)-1 : log2(NARROW_W/8)].
REQ-011 SHALL drive m_araddr equal to s_araddr with the lane bits forced to 0; all other bits pass through unchanged.
REQ-012 SHALL keep the AR path combinational with zero added latency:
- m_arvalid = s_arvalid && !flush && outstanding<MAX_OUTSTANDING
- s_arready = m_arready && !flush && outstanding<MAX_OUTSTANDING
REQ-013 SHALL push one entry {lane, discard=0} into an internal FIFO of depth MAX_OUTSTANDING on every AR handshake.
REQ-014 SHALL refuse a push when outstanding==MAX_OUTSTANDING, even if a pop occurs in the same cycle.
REQ-015 SHALL pop the FIFO head on every m_rvalid && m_rready handshake.
REQ-016 SHALL update outstanding as +1 on push, -1 on pop, and unchanged on simultaneous push and pop.
REQ-017 SHALL treat the head as forwarded when the FIFO is non-empty, the head discard bit is 0 and flush=0. For a forwarded head:
- s_rvalid = m_rvalid
- m_rready = s_rready
- s_rdata = m_rdata[lane*NARROW_W +: NARROW_W]
- s_rresp = m_rresp
REQ-018 SHALL treat the head as dropped when the FIFO is non-empty and either its discard bit is 1 or flush=1. For a dropped head: s_rvalid=0 and m_rready=1, so the response is consumed silently.
REQ-019 SHALL drive m_rready=0 and s_rvalid=0 when the FIFO is empty.
REQ-020 SHALL set err_unexpected_rsp on any cycle with the FIFO empty and m_rvalid=1, and hold it until reset.
REQ-021 SHALL, on a flush cycle, set the discard bit of every FIFO entry that remains after that cycle's pop.
REQ-022 SHALL accept no push during a flush cycle (guaranteed by REQ-012).
REQ-023 SHALL accept new reads from the first cycle after flush deasserts; those reads are forwarded normally.
REQ-024 SHALL handle FIFO pointer wrap-around modulo MAX_OUTSTANDING, including non-power-of-two depths.
REQ-025 SHALL keep s_rdata, s_rresp and m_araddr free of registers; the only state is the FIFO, its pointers, the outstanding count and err_unexpected_rsp.

Reset
REQ-026 SHALL, while rst=1, immediately force:
- FIFO empty, outstanding=0, err_unexpected_rsp=0
- s_arready=0, m_arvalid=0, s_rvalid=0, m_rready=0
REQ-027 SHALL, on reset mid-operation, discard all pending FIFO entries and hold no memory of them afterwards.
REQ-028 SHALL, in the first clk edge after rst deasserts, behave as an idle adapter with an empty FIFO.

Verification
REQ-029 Basic read, default parameters:
- s_araddr=0x1004 handshakes -> m_araddr=0x1000
- m_rdata=0xAAAA_BBBB_CCCC_DDDD returned -> s_rdata=0xAAAA_BBBB, outstanding returns 0
REQ-030 Pipelined reads:
- 4 back-to-back reads to 0x0, 0x4, 0x8, 0xC with m_rvalid delayed -> outstanding=4 and s_arready=0
- responses returned in order -> lanes low, high, low, high selected correctly
REQ-031 Full boundary:
- outstanding=4 with a pop and a new s_arvalid in the same cycle -> no push, outstanding=3 next cycle
REQ-032 Flush:
- 3 reads outstanding, 1-cycle flush -> next 3 responses consumed with s_rvalid=0
- a following read to 0x24 -> upper lane delivered
REQ-033 Error and backpressure:
- m_rvalid=1 with FIFO empty -> err_unexpected_rsp=1 sticky, m_rready=0
- s_rready=0 on a forwarded head -> m_rready=0, data held until s_rready=1
REQ-034 Reset and width generalisation:
- rst pulsed with 2 reads outstanding -> outstanding=0, err cleared
- WIDE_W=128, NARROW_W=32, address 0x...C -> s_rdata = m_rdata[127:96]
